// File: rtl/mod_mul_serial_256.sv
// Bit-serial (a*b) mod MODULUS over p = 2^256-189, using MSB-first interleaved double-and-add.
// Define MODMUL_RADIX4_EN to retire two multiplier bits per RUN cycle (128-cycle latency).
module mod_mul_serial_256 #(
    parameter int               WIDTH   = 256,
    parameter logic [WIDTH-1:0] MODULUS = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF43
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_next;
    logic             last_step;

    // One doubling and one conditional add, each reduced with a single
    // WIDTH+1-bit compare/subtract so the sum never overflows before the compare.
    function automatic logic [WIDTH-1:0] dbl_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             bit_in);
        logic [WIDTH:0] m;
        logic [WIDTH:0] t;
        logic [WIDTH:0] u;
        m = {1'b0, MODULUS};
        t = {x, 1'b0};
        if (t >= m) t = t - m;
        u = t + (bit_in ? {1'b0, y} : {(WIDTH+1){1'b0}});
        if (u >= m) u = u - m;
        return u[WIDTH-1:0];
    endfunction

`ifdef MODMUL_RADIX4_EN
    logic [WIDTH-1:0] acc_mid;
    logic [CW-1:0]    cnt_lo;

    always_comb begin
        cnt_lo    = cnt - CW'(1);
        acc_mid   = dbl_add(acc, a_r, b_r[cnt]);
        acc_next  = dbl_add(acc_mid, a_r, b_r[cnt_lo]);
        last_step = (cnt == CW'(1));
    end
`else
    always_comb begin
        acc_next  = dbl_add(acc, a_r, b_r[cnt]);
        last_step = (cnt == '0);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // a < 2^WIDTH < 2*MODULUS, so one subtraction fully reduces it.
                        a_r      <= (a >= MODULUS) ? a - MODULUS : a;
                        b_r      <= b;
                        acc      <= '0;
                        cnt      <= CW'(WIDTH - 1);
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_next;
`ifdef MODMUL_RADIX4_EN
                    cnt <= cnt - CW'(2);
`else
                    cnt <= cnt - CW'(1);
`endif
                    if (last_step) begin
                        result    <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mul_serial_256.sv
// Testbench for mod_mul_serial_256: directed vector table, handshake corner sequences and
// random products, all checked against an expected-result scoreboard built from a*b % p.
module tb_mod_mul_serial_256;

    localparam int               W      = 256;
    localparam logic [W-1:0]     P      = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF43;
    localparam int               BUDGET = 1000;
`ifdef MODMUL_RADIX4_EN
    localparam int               LAT    = 128;
`else
    localparam int               LAT    = 256;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int           errors = 0;
    int           checks = 0;
    int           n_in   = 0;
    int           n_out  = 0;
    logic [W-1:0] sb[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mod_mul_serial_256 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // Reference product built from full-width multiplication and division.
    function automatic logic [W-1:0] ref_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] prod;
        logic [2*W-1:0] rem;
        prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        rem  = prod % {{W{1'b0}}, P};
        return rem[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < W / 32; k++) r = {r[W-33:0], 32'($urandom())};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
        int n;
        n        = 0;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        while (!in_ready && n < BUDGET) begin
            tick();
            n++;
        end
        check("accept_wait", W'(in_ready), W'(1));
        tick();
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        sb.push_back(ref_mod(av, bv));
        n_in++;
    endtask

    task automatic checkOutput(input int stall, input bit check_lat);
        int           n;
        logic [W-1:0] exp;
        n = 0;
        while (!out_valid && n < BUDGET) begin
            tick();
            n++;
        end
        check("out_valid_wait", W'(out_valid), W'(1));
        if (check_lat) check("latency", W'(n), W'(LAT));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_underflow: got output %h expected none", result);
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
        check("result", result, exp);
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            check("stall_out_valid", W'(out_valid), W'(1));
            check("stall_result", result, exp);
            check("stall_in_ready", W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        tick();
        check("post_hs_out_valid", W'(out_valid), W'(0));
        check("post_hs_in_ready", W'(in_ready), W'(1));
        check("post_hs_result_held", result, exp);
        n_out++;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] av;
        logic [W-1:0] bv;

        vecs.push_back('{a: W'(2), b: W'(3), exp: W'(6)});
        vecs.push_back('{a: P - W'(1), b: P - W'(1), exp: W'(1)});
        vecs.push_back('{a: P - W'(1), b: W'(2), exp: P - W'(2)});
        vecs.push_back('{a: P, b: W'(5), exp: W'(0)});
        vecs.push_back('{a: {W{1'b1}}, b: W'(2), exp: W'(376)});
        vecs.push_back('{a: W'(0), b: W'(12345), exp: W'(0)});
        vecs.push_back('{a: W'(98765), b: W'(0), exp: W'(0)});
        vecs.push_back('{a: W'(1), b: P - W'(1), exp: P - W'(1)});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) tick();
        check("reset_in_ready", W'(in_ready), W'(1));
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_busy", W'(busy), W'(0));
        check("reset_result", result, '0);
        rst_n = 1'b1;
        tick();

        // Directed table: the hand-written expectations must agree with the reference model too.
        for (int i = 0; i < vecs.size(); i++) begin
            check("table_vs_ref", ref_mod(vecs[i].a, vecs[i].b), vecs[i].exp);
            applyStimulus(vecs[i].a, vecs[i].b);
            check("run_busy", W'(busy), W'(1));
            checkOutput(0, 1'b1);
        end

        $display("[TB] backpressure sequence");
        applyStimulus(W'(7), W'(9));
        checkOutput(20, 1'b1);
        check("bp_value", W'(63), ref_mod(W'(7), W'(9)));

        $display("[TB] busy-ignore sequence");
        applyStimulus(W'(5), W'(6));
        repeat (10) tick();
        check("ign_busy", W'(busy), W'(1));
        check("ign_in_ready", W'(in_ready), W'(0));
        a        = W'(11);
        b        = W'(13);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput(0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ign_no_second_out", W'(out_valid), W'(0));
            check("ign_idle_busy", W'(busy), W'(0));
        end

        $display("[TB] reset-abort sequence");
        applyStimulus(W'(9), W'(10));
        repeat (100) tick();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_result", result, '0);
        check("abort_in_ready", W'(in_ready), W'(1));
        check("abort_busy", W'(busy), W'(0));
        void'(sb.pop_back());
        n_in--;
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(W'(3), W'(4));
        checkOutput(0, 1'b1);
        check("abort_next_value", W'(12), ref_mod(W'(3), W'(4)));

        $display("[TB] random products");
        for (int i = 0; i < 40; i++) begin
            av = rand256();
            bv = rand256();
            if (i % 10 == 3) av = P - W'($urandom_range(0, 3));
            if (i % 10 == 7) bv = {W{1'b1}} - W'($urandom_range(0, 3));
            applyStimulus(av, bv);
            checkOutput(int'($urandom_range(0, 3)), 1'b1);
        end

        check("scoreboard_empty", W'(sb.size()), W'(0));
        check("in_out_count", W'(n_out), W'(n_in));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
